// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the input conditioner.
//   - chan_state_e : per-channel debounce FSM state encoding
//   - DEBOUNCE_CYCLES_DEFAULT : default hold time (10 ms at 50 MHz)
//   - SW_IN / SW_OUT : bit positions of the entering / leaving switches
package input_conditioner_pkg;

  // Waiting for a change (StStable) or timing a candidate change (StCheck).
  typedef enum logic {
    StStable = 1'b0,
    StCheck  = 1'b1
  } chan_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int unsigned CNT_W_DEFAULT           = 19;

  localparam int unsigned SW_IN  = 1;
  localparam int unsigned SW_OUT = 0;

endpackage

// File: rtl/input_conditioner_if.sv
// Bundle of raw board inputs and conditioned outputs of the input conditioner.
//   SW_RAW[1:0]   raw switches, [1] = entering, [0] = leaving
//   KEY_RAW       raw push-button, active-low
//   SW_CLEAN      debounced switch levels
//   SW_RISE/FALL  one-cycle edge pulses of SW_CLEAN
//   KEY_PRESSED   debounced button level, 1 = held
//   KEY_PULSE     one-cycle pulse on debounced press
//   BOTH_SW       registered SW_CLEAN[1] & SW_CLEAN[0]
// master: drives the raw inputs (board / bench side).
// slave : the conditioner itself.
interface input_conditioner_if;

  logic [1:0] SW_RAW;
  logic       KEY_RAW;
  logic [1:0] SW_CLEAN;
  logic [1:0] SW_RISE;
  logic [1:0] SW_FALL;
  logic       KEY_PRESSED;
  logic       KEY_PULSE;
  logic       BOTH_SW;

  modport master (
    output SW_RAW,
    output KEY_RAW,
    input  SW_CLEAN,
    input  SW_RISE,
    input  SW_FALL,
    input  KEY_PRESSED,
    input  KEY_PULSE,
    input  BOTH_SW
  );

  modport slave (
    input  SW_RAW,
    input  KEY_RAW,
    output SW_CLEAN,
    output SW_RISE,
    output SW_FALL,
    output KEY_PRESSED,
    output KEY_PULSE,
    output BOTH_SW
  );

endinterface

// File: rtl/input_conditioner_debounce_channel.sv
// One debounce channel: 2-flop synchronizer, STABLE/CHECK FSM with hold
// counter, clean level register and registered one-cycle rise/fall pulses.
//   clk    system clock, rising edge
//   rst    asynchronous active-high reset
//   raw    asynchronous input bit
//   clean  debounced level
//   rise   one-cycle pulse when clean goes 0->1
//   fall   one-cycle pulse when clean goes 1->0
// SYNC_RST_VAL sets the synchronizer reset value; INVERT flips the
// synchronized bit so an active-low source is seen as active-high.
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT,
  parameter bit          SYNC_RST_VAL    = 1'b0,
  parameter bit          INVERT          = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  if ((64'd1 << CNT_W) < 64'(DEBOUNCE_CYCLES)) begin : g_bad_width
    $error("CNT_W too narrow for DEBOUNCE_CYCLES");
  end

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level;
  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clean_q, clean_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Inversion happens after the synchronizer so the flops still reset to
  // the source's idle level.
  assign level = INVERT ? ~sync2_q : sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= SYNC_RST_VAL;
      sync2_q <= SYNC_RST_VAL;
      state_q <= StStable;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      StStable: begin
        if (level != clean_q) begin
          state_d = StCheck;
          cnt_d   = '0;
        end
      end
      StCheck: begin
        if (level == clean_q) begin
          // Glitch: input went back before the hold time elapsed.
          state_d = StStable;
        end else if (cnt_q == CntLast) begin
          clean_d = ~clean_q;
          rise_d  = ~clean_q;
          fall_d  = clean_q;
          state_d = StStable;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StStable;
    endcase
  end

  assign clean = clean_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// Front-end conditioner for the entry/exit control FSM. Synchronizes and
// debounces two slide switches and the active-low push-button, producing
// clean levels and one-cycle edge pulses.
//   CLK  system clock, rising edge
//   RST  asynchronous active-high reset
//   io   input_conditioner_if.slave (raw inputs in, conditioned outputs out)
// The KEY channel inverts after synchronization (flops reset to released);
// only its press pulse is exported. BOTH_SW is SW_CLEAN[1] & SW_CLEAN[0]
// delayed by one register.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input logic                   CLK,
  input logic                   RST,
  input_conditioner_if.slave    io
);

  logic [1:0] sw_clean;
  logic [1:0] sw_rise;
  logic [1:0] sw_fall;
  logic       key_clean;
  logic       key_rise;
  logic       key_fall_unused;
  logic       both_q;

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .SYNC_RST_VAL    (1'b0),
    .INVERT          (1'b0)
  ) u_sw_in (
    .clk   (CLK),
    .rst   (RST),
    .raw   (io.SW_RAW[SW_IN]),
    .clean (sw_clean[SW_IN]),
    .rise  (sw_rise[SW_IN]),
    .fall  (sw_fall[SW_IN])
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .SYNC_RST_VAL    (1'b0),
    .INVERT          (1'b0)
  ) u_sw_out (
    .clk   (CLK),
    .rst   (RST),
    .raw   (io.SW_RAW[SW_OUT]),
    .clean (sw_clean[SW_OUT]),
    .rise  (sw_rise[SW_OUT]),
    .fall  (sw_fall[SW_OUT])
  );

  // Button is active-low on the board: synchronizer idles at 1 (released),
  // then the channel sees 1 = pressed.
  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .SYNC_RST_VAL    (1'b1),
    .INVERT          (1'b1)
  ) u_key (
    .clk   (CLK),
    .rst   (RST),
    .raw   (io.KEY_RAW),
    .clean (key_clean),
    .rise  (key_rise),
    .fall  (key_fall_unused)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      both_q <= 1'b0;
    end else begin
      both_q <= sw_clean[SW_IN] & sw_clean[SW_OUT];
    end
  end

  assign io.SW_CLEAN    = sw_clean;
  assign io.SW_RISE     = sw_rise;
  assign io.SW_FALL     = sw_fall;
  assign io.KEY_PRESSED = key_clean;
  assign io.KEY_PULSE   = key_rise;
  assign io.BOTH_SW     = both_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Randomized and directed bench for input_conditioner (DEBOUNCE_CYCLES = 4)
// against a "hold for N consecutive samples" reference model.
module tb_input_conditioner;

  localparam int unsigned D = 4;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  input_conditioner_if io ();

  input_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (3)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .io  (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model. Channel index: 2 = SW[1], 1 = SW[0], 0 = KEY (pressed=1).
  // A new level is accepted once it has been seen on D+1 consecutive edges,
  // where the level seen at an edge is the raw value sampled two edges before.
  logic [2:0] hist[$];
  bit         m_clean[3];
  int         m_run[3];
  bit         m_rise[3];
  bit         m_fall[3];
  bit         m_both;

  task automatic model_reset();
    hist = {};
    hist.push_back(3'b000);
    hist.push_back(3'b000);
    for (int c = 0; c < 3; c++) begin
      m_clean[c] = 1'b0;
      m_run[c]   = 0;
      m_rise[c]  = 1'b0;
      m_fall[c]  = 1'b0;
    end
    m_both = 1'b0;
  endtask

  task automatic model_edge(input logic [1:0] sw, input logic key);
    logic [2:0] lvl;
    hist.push_back({sw[1], sw[0], ~key});
    lvl = hist[0];
    void'(hist.pop_front());
    m_both = m_clean[2] & m_clean[1];
    for (int c = 0; c < 3; c++) begin
      m_rise[c] = 1'b0;
      m_fall[c] = 1'b0;
      if (lvl[c] != m_clean[c]) begin
        m_run[c]++;
        if (m_run[c] == int'(D) + 1) begin
          m_clean[c] = ~m_clean[c];
          m_rise[c]  = m_clean[c];
          m_fall[c]  = ~m_clean[c];
          m_run[c]   = 0;
        end
      end else begin
        m_run[c] = 0;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("sw_clean", 32'(io.SW_CLEAN), 32'({m_clean[2], m_clean[1]}));
    check_eq("sw_rise", 32'(io.SW_RISE), 32'({m_rise[2], m_rise[1]}));
    check_eq("sw_fall", 32'(io.SW_FALL), 32'({m_fall[2], m_fall[1]}));
    check_eq("key_pressed", 32'(io.KEY_PRESSED), 32'(m_clean[0]));
    check_eq("key_pulse", 32'(io.KEY_PULSE), 32'(m_rise[0]));
    check_eq("both_sw", 32'(io.BOTH_SW), 32'(m_both));
  endtask

  // Observation trackers for directed latency / pulse-count checks.
  int edge_no, rise1_at, rise11_at, both_at, keyp_at;
  int n_rise1, n_rise0, n_fall, n_keyp;

  task automatic obs_clear();
    edge_no = 0; rise1_at = 0; rise11_at = 0; both_at = 0; keyp_at = 0;
    n_rise1 = 0; n_rise0 = 0; n_fall = 0; n_keyp = 0;
  endtask

  task automatic cycle(input logic [1:0] sw, input logic key);
    io.SW_RAW  = sw;
    io.KEY_RAW = key;
    @(posedge clk);
    model_edge(sw, key);
    #1;
    compare_all();
    edge_no++;
    if (io.SW_RISE[1]) begin
      n_rise1++;
      if (rise1_at == 0) rise1_at = edge_no;
    end
    if (io.SW_RISE[0]) n_rise0++;
    if (io.SW_RISE == 2'b11 && rise11_at == 0) rise11_at = edge_no;
    if (io.SW_FALL != 2'b00) n_fall++;
    if (io.BOTH_SW && both_at == 0) both_at = edge_no;
    if (io.KEY_PULSE) begin
      n_keyp++;
      if (keyp_at == 0) keyp_at = edge_no;
    end
  endtask

  task automatic hold(input logic [1:0] sw, input logic key, input int n);
    for (int i = 0; i < n; i++) cycle(sw, key);
  endtask

  // Asserts reset away from the clock edge, checks the asynchronous clear,
  // keeps it for n edges, then releases 1 time unit after an edge.
  task automatic apply_reset(input int n);
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      compare_all();
    end
    rst = 1'b0;
  endtask

  initial begin
    io.SW_RAW  = 2'b00;
    io.KEY_RAW = 1'b1;
    rst        = 1'b1;
    model_reset();
    obs_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    hold(2'b00, 1'b1, 4);

    // Mid-simulation reset from a non-idle state.
    hold(2'b11, 1'b0, 10);
    io.SW_RAW  = 2'b00;
    io.KEY_RAW = 1'b1;
    apply_reset(2);
    obs_clear();
    hold(2'b00, 1'b1, 1);
    check_eq("post_reset_no_pulse", 32'(io.SW_RISE | io.SW_FALL | io.KEY_PULSE), 32'd0);
    hold(2'b00, 1'b1, 4);

    // Clean press on SW[1].
    obs_clear();
    hold(2'b10, 1'b1, 10);
    check_eq("press_latency", 32'(rise1_at), 32'(D + 3));
    check_eq("press_pulses", 32'(n_rise1), 32'd1);
    check_eq("press_no_fall", 32'(n_fall), 32'd0);
    hold(2'b00, 1'b1, 10);

    // Glitch on SW[0].
    obs_clear();
    hold(2'b01, 1'b1, 2);
    hold(2'b00, 1'b1, 10);
    check_eq("glitch_no_rise", 32'(n_rise0), 32'd0);
    check_eq("glitch_clean", 32'(io.SW_CLEAN[0]), 32'd0);

    // Button press then release.
    obs_clear();
    hold(2'b00, 1'b0, 8);
    check_eq("key_latency", 32'(keyp_at), 32'(D + 3));
    check_eq("key_held", 32'(io.KEY_PRESSED), 32'd1);
    hold(2'b00, 1'b1, 8);
    check_eq("key_released", 32'(io.KEY_PRESSED), 32'd0);
    check_eq("key_pulses", 32'(n_keyp), 32'd1);

    // Simultaneous switch change.
    obs_clear();
    hold(2'b11, 1'b1, 10);
    check_eq("simul_rise_at", 32'(rise11_at), 32'(D + 3));
    check_eq("simul_both_at", 32'(both_at), 32'(D + 4));
    hold(2'b00, 1'b1, 10);

    // Reset while SW[1] is in CHECK; input kept high throughout.
    obs_clear();
    hold(2'b10, 1'b1, 2);
    io.SW_RAW = 2'b10;
    apply_reset(2);
    check_eq("midreset_clean", 32'(io.SW_CLEAN[1]), 32'd0);
    obs_clear();
    hold(2'b10, 1'b1, 10);
    check_eq("midreset_latency", 32'(rise1_at), 32'(D + 3));
    check_eq("midreset_pulses", 32'(n_rise1), 32'd1);
    hold(2'b00, 1'b1, 10);

    // Randomized segments of random hold length (some glitches, some accepted).
    for (int s = 0; s < 60; s++) begin
      logic [1:0] rsw;
      logic       rkey;
      rsw  = 2'($urandom_range(0, 3));
      rkey = 1'($urandom_range(0, 1));
      hold(rsw, rkey, int'($urandom_range(1, 9)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
